// File: rtl/tdm_demux_pkg.sv
// Shared TDM framing definitions: state encodings, default geometry, channel slice helper.
// Channel k of a frame word occupies bits [chan_lsb(k,W) +: W] on both the mux and demux sides.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_N  = 4;
    localparam int TDM_W  = 1;
    localparam int TDM_SW = 2;

    function automatic int chan_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index counter: clear > load-to-1 > increment priority; 1 clk update.
// No backpressure; the caller qualifies every control with its sample valid.
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int SW = TDM_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SW'(1);
        end else if (inc) begin
            cnt <= cnt + SW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: rebuilds N-channel frames from a serial slot stream; 1 clk last-slot to o.
// No backpressure: every valid sample is consumed, gaps (valid=0) freeze all state.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int W  = TDM_W,
    parameter int N  = TDM_N,
    parameter int SW = TDM_SW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   d,
    input  logic           valid,
    input  logic           sync,
    output logic [N*W-1:0] o,
    output logic           o_valid,
    output logic [SW-1:0]  slot,
    output logic           locked,
    output logic           sync_err
);

    tdm_state_e     state;
    logic [W-1:0]   hold [0:N-2];
    logic [N*W-1:0] frame_nxt;

    logic is_locked;
    logic slot_zero;
    logic slot_last;
    logic sync_start;
    logic miss_sync;
    logic early_sync;
    logic adv;
    logic complete;

    always_comb begin
        is_locked  = (state == LOCKED);
        slot_zero  = (slot == '0);
        slot_last  = (slot == SW'(N - 1));
        sync_start = valid & sync;
        miss_sync  = valid & ~sync & is_locked & slot_zero;
        adv        = valid & ~sync & is_locked & ~slot_zero;
        early_sync = sync_start & is_locked & ~slot_zero;
        complete   = adv & slot_last;
    end

    // The last slot bypasses the holding bank and lands straight in o.
    always_comb begin
        frame_nxt = '0;
        for (int k = 0; k < N - 1; k++) begin
            frame_nxt[chan_lsb(k, W) +: W] = hold[k];
        end
        frame_nxt[chan_lsb(N - 1, W) +: W] = d;
    end

    tdm_slot_counter #(
        .SW (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (miss_sync),
        .load1 (sync_start),
        .inc   (adv),
        .cnt   (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            locked   <= 1'b0;
            o        <= '0;
            o_valid  <= 1'b0;
            sync_err <= 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                hold[k] <= '0;
            end
        end else begin
            o_valid  <= complete;
            sync_err <= early_sync | miss_sync;

            // Any qualified sync (re)starts a frame; early sync keeps lock.
            if (sync_start) begin
                state  <= LOCKED;
                locked <= 1'b1;
            end else if (miss_sync) begin
                state  <= HUNT;
                locked <= 1'b0;
            end

            if (sync_start) begin
                hold[0] <= d;
            end
            for (int k = 1; k < N - 1; k++) begin
                if (adv && (slot == SW'(k))) begin
                    hold[k] <= d;
                end
            end

            if (complete) begin
                o <= frame_nxt;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed plus random bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] d;
    logic       valid;
    logic       sync;
    logic [3:0] o;
    logic       o_valid;
    logic [1:0] slot;
    logic       locked;
    logic       sync_err;

    int total = 0;
    int bad   = 0;

    // Reference model: collected samples of the frame in progress.
    bit         m_lock;
    bit         m_cur[$];
    logic [3:0] m_frame;
    bit         m_ov;
    bit         m_err;

    tdm_demux dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .valid    (valid),
        .sync     (sync),
        .o        (o),
        .o_valid  (o_valid),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lock  = 1'b0;
        m_cur.delete();
        m_frame = 4'b0;
        m_ov    = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit dd);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (!m_lock) begin
                if (s) begin
                    m_cur.delete();
                    m_cur.push_back(dd);
                    m_lock = 1'b1;
                end
            end else if (s) begin
                if (m_cur.size() != 0) m_err = 1'b1;
                m_cur.delete();
                m_cur.push_back(dd);
            end else if (m_cur.size() == 0) begin
                m_err  = 1'b1;
                m_lock = 1'b0;
            end else begin
                m_cur.push_back(dd);
                if (m_cur.size() == N) begin
                    for (int k = 0; k < N; k++) m_frame[k] = m_cur[k];
                    m_ov = 1'b1;
                    m_cur.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int exp_slot;
        exp_slot = m_lock ? m_cur.size() : 0;
        chk({tag, ".o"},        32'(o),        32'(m_frame));
        chk({tag, ".o_valid"},  32'(o_valid),  32'(m_ov));
        chk({tag, ".slot"},     32'(slot),     32'(exp_slot));
        chk({tag, ".locked"},   32'(locked),   32'(m_lock));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
    endtask

    task automatic step(input bit v, input bit s, input bit dd, input string tag);
        valid = v;
        sync  = s;
        d     = dd;
        @(posedge clk);
        model_step(v, s, dd);
        #1;
        check_all(tag);
    endtask

    task automatic gap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        sync  = 1'b0;
        d     = 1'b0;
        model_reset();
        #7;
        check_all("reset");
        rst = 1'b0;

        // Frame 1,0,1,0 straight after reset.
        step(1, 1, 1, "f1");
        step(1, 0, 0, "f1");
        step(1, 0, 1, "f1");
        step(1, 0, 0, "f1");
        chk("f1_lit_o", 32'(o), 32'(4'b0101));
        chk("f1_lit_ov", 32'(o_valid), 32'(1));
        step(0, 0, 0, "f1_idle");
        chk("f1_pulse", 32'(o_valid), 32'(0));

        // Same frame with 3-cycle gaps; sync toggles randomly while idle.
        step(1, 1, 1, "gap"); gap(3, "gap_i");
        step(1, 0, 0, "gap"); gap(3, "gap_i");
        step(1, 0, 1, "gap"); gap(3, "gap_i");
        step(1, 0, 0, "gap");
        chk("gap_lit_o", 32'(o), 32'(4'b0101));
        gap(2, "gap_i");

        // Early sync aborts the partial frame.
        step(1, 1, 1, "early");
        step(1, 0, 1, "early");
        step(1, 1, 0, "early");
        chk("early_err", 32'(sync_err), 32'(1));
        chk("early_hold_o", 32'(o), 32'(4'b0101));
        step(1, 0, 1, "early");
        step(1, 0, 1, "early");
        step(1, 0, 0, "early");
        chk("early_lit_o", 32'(o), 32'(4'b0110));

        // Missing sync drops lock; non-sync samples then ignored.
        step(1, 0, 1, "miss");
        chk("miss_err", 32'(sync_err), 32'(1));
        chk("miss_lock", 32'(locked), 32'(0));
        step(1, 0, 0, "miss_ign");
        step(1, 0, 1, "miss_ign");
        step(1, 1, 1, "miss");
        step(1, 0, 1, "miss");
        step(1, 0, 1, "miss");
        step(1, 0, 1, "miss");
        chk("miss_lit_o", 32'(o), 32'(4'b1111));

        // Back-to-back frames 0101 then 1010.
        step(1, 1, 1, "b2b"); step(1, 0, 0, "b2b"); step(1, 0, 1, "b2b"); step(1, 0, 0, "b2b");
        chk("b2b_lit_o1", 32'(o), 32'(4'b0101));
        step(1, 1, 0, "b2b"); step(1, 0, 1, "b2b"); step(1, 0, 0, "b2b"); step(1, 0, 1, "b2b");
        chk("b2b_lit_o2", 32'(o), 32'(4'b1010));
        chk("b2b_lit_ov2", 32'(o_valid), 32'(1));

        // Asynchronous reset between edges after two samples.
        step(1, 1, 0, "arst_pre");
        step(1, 0, 0, "arst_pre");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        #2;
        rst = 1'b0;
        step(1, 1, 0, "post");
        step(1, 0, 0, "post");
        step(1, 0, 1, "post");
        step(1, 0, 1, "post");
        chk("post_lit_o", 32'(o), 32'(4'b1100));

        // Random traffic with gaps and framing faults.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the 4:1 channel mux path. Takes a time-division-multiplexed serial sample stream (one channel per valid slot, slot 0 flagged by a frame sync) and distributes it back onto N parallel channel outputs.
- Holds partial frames internally and presents a complete, registered N-channel word with a one-cycle valid strobe.
- Sits directly downstream of the mux-based TDM transmitter, on the same clock.

Parameters:
- W, 1, bit width of one channel sample; 1 matches the mux output width.
- N, 4, channels per frame; must be a power of 2 and at least 2.
- SW, 2, slot index width; equals log2(N).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  W  serial sample for the current slot.
- valid  input  1  d is a sample this cycle; gaps (valid=0) are allowed anywhere.
- sync  input  1  qualified by valid; marks d as the slot-0 sample.
- o  output  N*W  demultiplexed frame; channel k occupies o[k*W +: W].
- o_valid  output  1  one-cycle pulse; o updated with a new complete frame.
- slot  output  SW  index of the next expected slot (the receive-side counterpart of the mux select).
- locked  output  1  high while aligned to the frame.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Reset values (async assert, takes effect immediately):
  - state=HUNT, slot=0, o=0, o_valid=0, locked=0, sync_err=0.
  - All holding registers are 0.
  - Deassertion is sampled on the next rising clk.
- Idle cycles: valid=0 leaves all state unchanged. o_valid and sync_err return to 0 (they are pulses).
- HUNT state:
  - valid & ~sync: sample discarded, no error.
  - valid & sync: d is written to hold[0]; slot<=1; state<=LOCKED; locked<=1.
- LOCKED state, on valid:
  - sync & slot==0: normal frame start. Write hold[0]; slot<=1.
  - ~sync & slot!=0: write hold[slot]; slot<=slot+1, wrapping modulo N.
  - sync & slot!=0 (early sync): sync_err pulse. The partial frame is discarded and no o_valid is generated. d is written to hold[0]; slot<=1; lock is kept.
  - ~sync & slot==0 (missing sync): sync_err pulse. Sample discarded; state<=HUNT; locked<=0; slot<=0.
- Frame completion:
  - When the sample for slot N-1 is accepted, o is loaded in the same edge with the held slots 0..N-2 plus the current d as channel N-1. o_valid=1 for exactly that following cycle.
  - Latency is 1 clk from the last-slot sample to o/o_valid.
- o holds its value between frames and is never partially updated.
- Back-to-back frames with no gaps are supported: a slot-0 sample in the cycle after completion is accepted normally.
- sync while valid=0 is ignored.
- Reset mid-frame: partial data is lost, o is cleared, and the block re-enters HUNT.

Decomposition:
- Shared include tdm_defs.vh holds:
  - the state encodings HUNT=1'b0 and LOCKED=1'b1;
  - the default N, W and SW;
  - the channel-slice convention o[k*W +: W], so the transmitter and receiver agree on channel ordering.
- One natural sub-module: tdm_slot_counter, an SW-bit wrapping counter with synchronous load-to-1, clear, and increment-on-enable, plus the async reset.
- The holding bank and the output register stay in tdm_demux.

Test Plan:
- Reset then frame: valid=1 with (sync,d)=(1,1),(0,0),(0,1),(0,0) -> one cycle after the 4th sample, o=4'b0101, o_valid=1 for 1 cycle, locked=1, sync_err never asserted.
- Gapped frame: same samples as above with valid=0 for 3 cycles between each sample -> identical o=4'b0101. o_valid pulses once; slot steps 1,2,3,0 only on valid cycles.
- Early sync:
  - Stimulus: the (sync,d)=(1,1),(0,1) frame start, then (1,0),(0,1),(0,1),(0,0).
  - Response: sync_err pulses at the third sample and there is no o_valid for the aborted frame; the next o_valid gives o=4'b0110.
  - Check that o is unchanged from its prior value before that.
- Missing sync: after a good frame, send (sync,d)=(0,1) at slot 0 -> sync_err pulse, locked=0, slot=0. Non-sync samples are then ignored until the next sync, and the following complete frame 1,1,1,1 gives o=4'b1111.
- Back-to-back frames: 0101 followed immediately by 1010 with no gap -> o_valid pulses exactly 4 cycles apart; o=4'b0101 then 4'b1010.
- Reset mid-frame: assert rst asynchronously (between edges) after 2 samples -> o=0, o_valid=0, locked=0 and slot=0 immediately. After release, a fresh frame 0011 gives o=4'b1100 (channel 0 in the LSB).
